// File: rtl/util_dac_diff_buf.sv
// util_dac_diff_buf: maps per-channel differential pairs to DAC codes, packs the channels into one word,
// queues it in a first-word-fall-through FIFO and tracks per-channel line idle.
module util_dac_diff_buf #(
    parameter int                    CHANNELS    = 2,
    parameter int                    BYTE_WIDTH  = 16,
    parameter logic [BYTE_WIDTH-1:0] ONEZERO_OUT = 16'h7FFF,
    parameter logic [BYTE_WIDTH-1:0] ZEROONE_OUT = 16'h8000,
    parameter logic [BYTE_WIDTH-1:0] SAME_OUT    = '0,
    parameter int                    FIFO_DEPTH  = 16,
    parameter int                    IDLE_COUNT  = 8
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic [2*CHANNELS-1:0]          diff_in,
    input  logic                           diff_en,
    output logic [BYTE_WIDTH*CHANNELS-1:0] rd_data,
    output logic                           rd_valid,
    input  logic                           rd_ready,
    output logic                           rd_dunf,
    output logic                           wr_ovf,
    output logic [CHANNELS-1:0]            idle,
    output logic [$clog2(FIFO_DEPTH):0]    level
);
    localparam int W  = BYTE_WIDTH * CHANNELS;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = $clog2(IDLE_COUNT + 1);

    logic [W-1:0]    stage_q, stage_d, map_w;
    logic            stage_vld_q, stage_vld_d;
    logic [W-1:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]   level_q, level_d;
    logic            ovf_q, ovf_d, dunf_q, dunf_d;
    logic [CW-1:0]   icnt_q [CHANNELS];
    logic [CW-1:0]   icnt_d [CHANNELS];
    logic [CHANNELS-1:0] idle_q, idle_d;
    logic            push, pop, full;

    assign rd_valid = (level_q != '0);
    assign full     = (level_q == LW'(FIFO_DEPTH));
    assign pop      = rd_valid && rd_ready;
    // A full FIFO still accepts the stage word when the head leaves on the same edge.
    assign push     = stage_vld_q && (!full || pop);
    assign rd_data  = rd_valid ? mem_q[rd_ptr_q] : '0;
    assign rd_dunf  = dunf_q;
    assign wr_ovf   = ovf_q;
    assign idle     = idle_q;
    assign level    = level_q;

    always_comb begin
        map_w       = '0;
        icnt_d      = icnt_q;
        idle_d      = idle_q;
        for (int c = 0; c < CHANNELS; c++) begin
            map_w[BYTE_WIDTH*c +: BYTE_WIDTH] = (diff_in[2*c +: 2] == 2'b10) ? ONEZERO_OUT :
                                                (diff_in[2*c +: 2] == 2'b01) ? ZEROONE_OUT : SAME_OUT;
            if (diff_en) begin
                if (diff_in[2*c+1] ^ diff_in[2*c]) begin
                    icnt_d[c] = CW'(IDLE_COUNT);
                    idle_d[c] = 1'b0;
                end else begin
                    icnt_d[c] = (icnt_q[c] == '0) ? '0 : icnt_q[c] - CW'(1);
                    idle_d[c] = idle_q[c] | (icnt_q[c] <= CW'(1));
                end
            end
        end
        stage_d     = diff_en ? map_w : stage_q;
        stage_vld_d = diff_en;
        wr_ptr_d    = wr_ptr_q + AW'(push);
        rd_ptr_d    = rd_ptr_q + AW'(pop);
        level_d     = level_q + LW'(push) - LW'(pop);
        ovf_d       = ovf_q | (stage_vld_q && full && !pop);
        dunf_d      = rd_ready && !rd_valid;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stage_q     <= '0;
            stage_vld_q <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            ovf_q       <= 1'b0;
            dunf_q      <= 1'b0;
            idle_q      <= '1;
            for (int c = 0; c < CHANNELS; c++) icnt_q[c] <= CW'(IDLE_COUNT);
        end else begin
            stage_q     <= stage_d;
            stage_vld_q <= stage_vld_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            ovf_q       <= ovf_d;
            dunf_q      <= dunf_d;
            idle_q      <= idle_d;
            icnt_q      <= icnt_d;
        end
    end

    // Storage needs no reset: entries are only visible through the occupancy count.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= stage_q;
    end
endmodule

// File: doc/util_dac_diff_buf.md
Name: util_dac_diff_buf

Overview:
- Multi-channel, buffered successor to the single-channel differential-to-DAC word converter.
- Per channel, samples a 2-bit differential pair {p,n} on enabled cycles and maps its state to a parametrised DAC code word.
- Packs all channels into one output word and queues it in a first-word-fall-through FIFO read with a valid/ready handshake.
- Adds per-channel idle (line-quiet) detection, overflow and underflow reporting; sits between the 1553 encoder differential output and the DAC sample stream.

Parameters:
- CHANNELS, 2, number of differential pairs.
- BYTE_WIDTH, 16, DAC code width per channel.
- ONEZERO_OUT, 16'h7FFF, code for {p,n}=2'b10.
- ZEROONE_OUT, 16'h8000, code for {p,n}=2'b01.
- SAME_OUT, 0, code for {p,n}=2'b00 or 2'b11.
- FIFO_DEPTH, 16, output FIFO entries; power of 2, minimum 2.
- IDLE_COUNT, 8, consecutive same-state samples before idle asserts; minimum 1.

Ports:
- clk  in  1  sole clock, rising edge.
- rstn  in  1  reset, asynchronous assert, active-low.
- diff_in  in  2*CHANNELS  channel c on bits [2c+1:2c], p=bit 2c+1.
- diff_en  in  1  sample diff_in this cycle.
- rd_data  out  BYTE_WIDTH*CHANNELS  channel c on bits [BYTE_WIDTH*(c+1)-1:BYTE_WIDTH*c].
- rd_valid  out  1  FIFO head valid.
- rd_ready  in  1  consumer accepts head.
- rd_dunf  out  1  underflow pulse.
- wr_ovf  out  1  sticky overflow.
- idle  out  CHANNELS  per-channel line idle.
- level  out  clog2(FIFO_DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset: asynchronous on rstn low; all state cleared while low.
  - Reset values: rd_data=0, rd_valid=0, rd_dunf=0, wr_ovf=0, level=0.
  - idle is all ones at reset (line quiet); idle counters are preloaded to IDLE_COUNT.
  - FIFO contents are discarded; stage register invalid.
- Map stage: on a clk edge with diff_en=1, each channel is mapped per its parameter code (10->ONEZERO_OUT, 01->ZEROONE_OUT, 00/11->SAME_OUT) into a stage register; stage_valid<=1.
  - With diff_en=0, stage_valid<=0.
- FIFO write: a valid stage word is written on the next edge.
  - Latency: a word sampled at edge k into an empty FIFO shows on rd_data with rd_valid=1 after edge k+1.
  - Throughput: 1 word/cycle.
- Read: pop on any edge where rd_valid&&rd_ready.
  - rd_data and rd_valid are held stable while rd_valid=1 and rd_ready=0.
- Simultaneous write and pop when full: both succeed; level unchanged; no overflow.
- Overflow: a write to a full FIFO with no pop drops the new word and sets wr_ovf=1. wr_ovf clears only on reset.
- Underflow: rd_ready=1 while rd_valid=0 gives rd_dunf=1 for the following cycle only. It is re-evaluated each cycle, so a held rd_ready on empty gives a continuous rd_dunf.
- level: count of words in the FIFO, updated on the same edge as the write or pop. Range 0..FIFO_DEPTH.
- Idle detector, per channel, evaluated only on diff_en cycles:
  - State 00/11: counter decrements, saturating at 0.
  - State 01/10: counter reloads to IDLE_COUNT and idle[c]<=0 on that edge.
  - idle[c]<=1 on the edge the counter transitions 1->0, and stays 1 while the counter is 0.
- diff_en=0: counters and idle hold.
- Reset mid-operation: the output is empty next cycle; no rd_dunf is generated by reset.

Test Plan:
- Reset release, diff_en=1, ch0=10, ch1=01, rd_ready=1 -> after 2 edges rd_data=32'h80007FFF, rd_valid=1, level=1, then steady streaming.
- Both channels 11 for 8 enabled samples after prior 10 -> idle=2'b11 on the 8th edge; a single 01 on ch0 -> idle[0]=0 the next edge, idle[1] stays 1.
- rd_ready=0, 20 enabled samples with FIFO_DEPTH=16 -> level=16, wr_ovf=1; the head word is unchanged and equals the first sample.
- Full FIFO, rd_ready=1 and diff_en=1 together for 5 cycles -> level stays 16, wr_ovf not newly set, output order preserved.
- Empty FIFO, diff_en=0, rd_ready=1 for 3 cycles -> rd_dunf=1 for 3 cycles, rd_valid=0, level=0.
- Assert rstn=0 asynchronously mid-stream with level=5 -> immediately rd_valid=0, level=0, wr_ovf=0, idle=all ones; no rd_dunf.
